uart_protocol: RTL and testbench
================================

# uart_protocol

Self-contained UART transmit/receive block with an internal loopback: a baud-tick transmitter serializes a parallel byte onto `tx_out`, and an oversampling receiver on the same clock deserializes `tx_out` back into `rx_data_out`. It is the top-level off-chip serial endpoint and the team's loopback reference for UART framing (start, data LSB-first, parity, stop).

## Interface
- `data_len`, default 8: data bits per frame.
- `clk_freq`, default 50000000: system clock frequency in Hz.
- `baud_rate`, default 9600: line rate in bit/s.
- `parity_type`, default 1: 1 = even parity, 0 = odd parity.

Ports:
- `clk`  in  1: single system clock for TX and RX.
- `rst`  in  1: reset, asynchronous, active-high.
- `tx_start`  in  1: transmit request; a single-cycle pulse is sufficient.
- `tx_data`  in  `data_len`: byte to send, sampled when the request is accepted.
- `baud_tick_tx`  out  1: one-clock TX baud strobe.
- `tx_out`  out  1: serial line, idle high; internally drives the RX input.
- `tx_done`  out  1: one-clock pulse at the end of the stop bit.
- `rx_done`  out  1: one-clock pulse when a valid frame is received.
- `rx_data_out`  out  `data_len`: last correctly received byte.

## Operation
- TX divisor `BAUD_DIV = clk_freq/baud_rate` (integer division; 5208 at defaults).
  - `baud_tick_tx` is free-running: high for 1 clk every `BAUD_DIV` clks.
  - The counter runs from reset release and is never gated by TX activity.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - In IDLE, a `tx_start` seen on any clock latches `tx_data` and sets a pending flag.
  - On the next `baud_tick_tx`, go to START and drive `tx_out=0`.
  - Each subsequent tick advances one bit:
    - DATA sends `data_len` bits, LSB first.
    - PARITY sends `^data` for even parity, `~^data` for odd.
    - STOP sends 1.
  - At the tick ending STOP: pulse `tx_done`, return to IDLE, `tx_out=1`.
  - `tx_start` outside IDLE is ignored (not queued).
- RX oversampling: `OS_DIV = clk_freq/(baud_rate*16)` (325 at defaults), giving a 16x tick.
  - RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - A falling edge on the line starts START. At 8 oversample ticks, re-check the line; if it is not 0, treat it as a glitch and return to IDLE.
  - After that, sample every 16 oversample ticks (mid-bit): data LSB first, then parity, then stop.
  - At the stop sample, a frame is valid if stop = 1 and parity matches `parity_type`. On a valid frame: load `rx_data_out` and pulse `rx_done`.
  - On a bad frame: no pulse, `rx_data_out` is kept; return to IDLE either way.
- The line input to RX is passed through a 2-flop synchronizer.

## Timing
- Reset values: `tx_out=1`, `tx_done=0`, `baud_tick_tx=0`, `rx_done=0`, `rx_data_out=0`; all counters 0; both FSMs in IDLE.
- Reset during a frame aborts it immediately; no done pulse is generated.
- Frame length is `data_len+3` bit periods (11 × 5208 clks ≈ 1.146 ms at defaults).
- TX start latency: request to the START edge is at most `BAUD_DIV` clks (next tick).
- `tx_done` asserts at the same clock as the tick that ends STOP.
- TX is back in IDLE on that clock, so a `tx_start` issued after the next tick is accepted (back-to-back frames).
- `rx_done` precedes the end of the TX stop bit by about half a bit period, plus the sync delay (~2 clks).
- When `tx_start` coincides with a tick while in IDLE, the request is latched and START begins on the following tick. START is never entered mid-tick.

## Structure
- Package `uart_pkg`:
  - `tx_state_t` and `rx_state_t` enums.
  - Helper function for the parity bit given `parity_type`.
- Sub-modules:
  - `uart_tx`: instance `dut_tx`, FSM variable named `state`, owns the baud divisor.
  - `uart_rx`: instance `dut_rx`, owns the oversample divisor.
- The top only wires them together with the loopback.

## Test plan
- Reset held 20 ns then released -> `tx_out=1`, all pulses 0; `baud_tick_tx` period is 5208 clks.
- Send 0xA5, even parity -> line 0,1,0,1,0,0,1,0,1, parity 0, stop 1; `tx_done` once; `rx_done` once with `rx_data_out=0xA5`.
- Three back-to-back random bytes, each started on the tick after the previous `tx_done` -> three `rx_done` pulses, each with matching data.
- `parity_type=0`, send 0x01 -> parity bit 0 on the line; byte received correctly.
- Assert `rst` mid-DATA -> `tx_out` returns to 1 immediately; no `tx_done`/`rx_done`; the next frame after release is correct.
- `tx_start` pulsed during DATA of frame 0x3C -> ignored; exactly one frame is sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART framing types and helpers for the loopback TX/RX pair.
package uart_pkg;

  localparam int unsigned OS_FACTOR = 16;
  localparam int unsigned OS_HALF   = OS_FACTOR / 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Zero-extension to 32 bits leaves the XOR reduction unchanged.
  function automatic logic calc_parity(input logic [31:0] data, input logic even_par);
    return even_par ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampling, mid-bit sampling, parity/stop validation.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned data_len    = 8,
  parameter int unsigned clk_freq    = 50000000,
  parameter int unsigned baud_rate   = 9600,
  parameter int unsigned parity_type = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_in,
  output logic                rx_done,
  output logic [data_len-1:0] rx_data_out
);

  localparam int unsigned OS_DIV = clk_freq / (baud_rate * OS_FACTOR);
  localparam int unsigned OW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam int unsigned IW = (data_len > 1) ? $clog2(data_len) : 1;

  logic [1:0]          r_sync;
  logic                r_line_prev;
  logic                w_line, w_fall;
  logic [OW-1:0]       r_os_cnt;
  logic                w_os_tick;
  rx_state_t           r_state, w_state_nxt;
  logic [3:0]          r_tick_cnt, w_tick_nxt;
  logic [IW-1:0]       r_idx, w_idx_nxt;
  logic [data_len-1:0] r_shift;
  logic                r_par_bit;
  logic                w_shift_en, w_par_en, w_frame_ok;
  logic                r_rx_done;
  logic [data_len-1:0] r_rx_data;

  assign w_line = r_sync[1];
  assign w_fall = r_line_prev & ~w_line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync      <= '1;
      r_line_prev <= 1'b1;
    end else begin
      r_sync      <= {r_sync[0], rx_in};
      r_line_prev <= w_line;
    end
  end

  // Divider is held in IDLE so oversample ticks are phased to the start edge.
  assign w_os_tick = (r_state != RX_IDLE) && (r_os_cnt == OW'(OS_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_os_cnt <= '0;
    else if (r_state == RX_IDLE || w_os_tick) r_os_cnt <= '0;
    else                                     r_os_cnt <= r_os_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RX_IDLE;
      r_tick_cnt <= '0;
      r_idx      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_idx      <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_idx_nxt   = r_idx;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_frame_ok  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_tick_nxt = '0;
        w_idx_nxt  = '0;
        if (w_fall) w_state_nxt = RX_START;
      end
      RX_START: begin
        if (w_os_tick) begin
          if (r_tick_cnt == 4'(OS_HALF - 1)) begin
            w_tick_nxt  = '0;
            w_state_nxt = w_line ? RX_IDLE : RX_DATA;
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (w_os_tick) begin
          if (r_tick_cnt == 4'(OS_FACTOR - 1)) begin
            w_tick_nxt = '0;
            w_shift_en = 1'b1;
            if (r_idx == IW'(data_len - 1)) w_state_nxt = RX_PARITY;
            else                            w_idx_nxt   = r_idx + 1'b1;
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (w_os_tick) begin
          if (r_tick_cnt == 4'(OS_FACTOR - 1)) begin
            w_tick_nxt  = '0;
            w_par_en    = 1'b1;
            w_state_nxt = RX_STOP;
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (w_os_tick) begin
          if (r_tick_cnt == 4'(OS_FACTOR - 1)) begin
            w_tick_nxt  = '0;
            w_state_nxt = RX_IDLE;
            w_frame_ok  = w_line &&
                          (r_par_bit == calc_parity(32'(r_shift), parity_type != 0));
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      r_rx_done <= 1'b0;
      r_rx_data <= '0;
    end else begin
      if (w_shift_en) r_shift <= {w_line, r_shift[data_len-1:1]};
      if (w_par_en)   r_par_bit <= w_line;
      r_rx_done <= w_frame_ok;
      if (w_frame_ok) r_rx_data <= r_shift;
    end
  end

  assign rx_done     = r_rx_done;
  assign rx_data_out = r_rx_data;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: free-running baud divider and START/DATA/PARITY/STOP serializer.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned data_len    = 8,
  parameter int unsigned clk_freq    = 50000000,
  parameter int unsigned baud_rate   = 9600,
  parameter int unsigned parity_type = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tx_start,
  input  logic [data_len-1:0] tx_data,
  output logic                baud_tick_tx,
  output logic                tx_out,
  output logic                tx_done
);

  localparam int unsigned BAUD_DIV = clk_freq / baud_rate;
  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned IW = (data_len > 1) ? $clog2(data_len) : 1;

  logic [CW-1:0]       r_baud_cnt;
  logic                w_tick;
  tx_state_t           state, w_state_nxt;
  logic                r_pending, w_pending_nxt;
  logic [data_len-1:0] r_data, w_data_nxt;
  logic [IW-1:0]       r_idx, w_idx_nxt;
  logic                r_tx_out, w_tx_out_nxt;
  logic                w_done;

  assign w_tick = (r_baud_cnt == CW'(BAUD_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_baud_cnt <= '0;
    else if (w_tick) r_baud_cnt <= '0;
    else             r_baud_cnt <= r_baud_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= TX_IDLE;
      r_pending <= 1'b0;
      r_data    <= '0;
      r_idx     <= '0;
      r_tx_out  <= 1'b1;
    end else begin
      state     <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_data    <= w_data_nxt;
      r_idx     <= w_idx_nxt;
      r_tx_out  <= w_tx_out_nxt;
    end
  end

  // tx_out is registered from the next-state decode so the line flips on the
  // clock after each tick and never glitches.
  always_comb begin
    w_state_nxt   = state;
    w_pending_nxt = r_pending;
    w_data_nxt    = r_data;
    w_idx_nxt     = r_idx;
    w_tx_out_nxt  = r_tx_out;
    w_done        = 1'b0;
    case (state)
      TX_IDLE: begin
        w_tx_out_nxt = 1'b1;
        if (r_pending && w_tick) begin
          w_state_nxt   = TX_START;
          w_pending_nxt = 1'b0;
          w_tx_out_nxt  = 1'b0;
        end else if (tx_start && !r_pending) begin
          w_pending_nxt = 1'b1;
          w_data_nxt    = tx_data;
        end
      end
      TX_START: begin
        if (w_tick) begin
          w_state_nxt  = TX_DATA;
          w_idx_nxt    = '0;
          w_tx_out_nxt = r_data[0];
        end
      end
      TX_DATA: begin
        if (w_tick) begin
          if (r_idx == IW'(data_len - 1)) begin
            w_state_nxt  = TX_PARITY;
            w_tx_out_nxt = calc_parity(32'(r_data), parity_type != 0);
          end else begin
            w_idx_nxt    = r_idx + 1'b1;
            w_tx_out_nxt = r_data[w_idx_nxt];
          end
        end
      end
      TX_PARITY: begin
        if (w_tick) begin
          w_state_nxt  = TX_STOP;
          w_tx_out_nxt = 1'b1;
        end
      end
      TX_STOP: begin
        if (w_tick) begin
          w_state_nxt  = TX_IDLE;
          w_tx_out_nxt = 1'b1;
          w_done       = 1'b1;
        end
      end
      default: begin
        w_state_nxt  = TX_IDLE;
        w_tx_out_nxt = 1'b1;
      end
    endcase
  end

  assign baud_tick_tx = w_tick;
  assign tx_out       = r_tx_out;
  assign tx_done      = w_done;

endmodule

// File: rtl/uart_protocol.sv
// UART endpoint: transmitter with its serial line looped back into the receiver.
module uart_protocol
  import uart_pkg::*;
#(
  parameter int unsigned data_len    = 8,
  parameter int unsigned clk_freq    = 50000000,
  parameter int unsigned baud_rate   = 9600,
  parameter int unsigned parity_type = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tx_start,
  input  logic [data_len-1:0] tx_data,
  output logic                baud_tick_tx,
  output logic                tx_out,
  output logic                tx_done,
  output logic                rx_done,
  output logic [data_len-1:0] rx_data_out
);

  logic w_line;

  uart_tx #(
    .data_len   (data_len),
    .clk_freq   (clk_freq),
    .baud_rate  (baud_rate),
    .parity_type(parity_type)
  ) dut_tx (
    .clk         (clk),
    .rst         (rst),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .baud_tick_tx(baud_tick_tx),
    .tx_out      (w_line),
    .tx_done     (tx_done)
  );

  uart_rx #(
    .data_len   (data_len),
    .clk_freq   (clk_freq),
    .baud_rate  (baud_rate),
    .parity_type(parity_type)
  ) dut_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (w_line),
    .rx_done    (rx_done),
    .rx_data_out(rx_data_out)
  );

  assign tx_out = w_line;

endmodule

// File: tb/tb_uart_protocol.sv
// Loopback bench: line-level frame checks plus a receive-data scoreboard.
module tb_uart_protocol;

  localparam int unsigned CLK_F = 6400000;
  localparam int unsigned BAUD  = 100000;
  localparam int unsigned BDIV  = CLK_F / BAUD;   // 64 clks per bit

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0, tx_start_o = 1'b0;
  logic [7:0] tx_data = '0, tx_data_o = '0;
  logic       baud_tick, tx_out, tx_done, rx_done;
  logic [7:0] rx_data;
  logic       baud_tick_o, tx_out_o, tx_done_o, rx_done_o;
  logic [7:0] rx_data_o;

  int n_total = 0, n_pass = 0, n_fail = 0;
  int cyc = 0;
  int tx_done_cnt = 0, rx_done_cnt = 0, tx_done_cnt_o = 0, rx_done_cnt_o = 0;
  logic [7:0] q[$];
  logic [7:0] q_o[$];

  uart_protocol #(.data_len(8), .clk_freq(CLK_F), .baud_rate(BAUD), .parity_type(1)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .baud_tick_tx(baud_tick), .tx_out(tx_out), .tx_done(tx_done),
    .rx_done(rx_done), .rx_data_out(rx_data)
  );

  uart_protocol #(.data_len(8), .clk_freq(CLK_F), .baud_rate(BAUD), .parity_type(0)) dut_odd (
    .clk(clk), .rst(rst), .tx_start(tx_start_o), .tx_data(tx_data_o),
    .baud_tick_tx(baud_tick_o), .tx_out(tx_out_o), .tx_done(tx_done_o),
    .rx_done(rx_done_o), .rx_data_out(rx_data_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (tx_done)   tx_done_cnt++;
    if (tx_done_o) tx_done_cnt_o++;
    if (rx_done) begin
      rx_done_cnt++;
      check("rx_q_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) check("rx_data", 32'(rx_data), 32'(q.pop_front()));
    end
    if (rx_done_o) begin
      rx_done_cnt_o++;
      check("rx_odd_q_nonempty", 32'(q_o.size() != 0), 32'd1);
      if (q_o.size() != 0) check("rx_odd_data", 32'(rx_data_o), 32'(q_o.pop_front()));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic line_of(input bit odd);
    return odd ? tx_out_o : tx_out;
  endfunction

  function automatic logic done_of(input bit odd);
    return odd ? tx_done_o : tx_done;
  endfunction

  task automatic drive_start(input bit odd, input logic [7:0] b);
    @(negedge clk);
    if (odd) begin tx_data_o = b; tx_start_o = 1'b1; q_o.push_back(b); end
    else     begin tx_data   = b; tx_start   = 1'b1; q.push_back(b);   end
    @(negedge clk);
    tx_start   = 1'b0;
    tx_start_o = 1'b0;
  endtask

  task automatic wait_low(input bit odd, input string tag);
    int n = 0;
    while (line_of(odd) !== 1'b0 && n < 3 * BDIV) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start_seen"}, 32'(line_of(odd)), 32'd0);
  endtask

  // Sample each bit mid-period from the start edge, then wait for tx_done.
  // inject_bit >= 0 pulses a spurious tx_start during that bit.
  task automatic check_frame(input bit odd, input logic [7:0] b, input string tag,
                             input int inject_bit);
    logic [10:0] f;
    int n;
    f[0]    = 1'b0;
    f[8:1]  = b;
    f[9]    = odd ? ~^b : ^b;
    f[10]   = 1'b1;
    wait_low(odd, tag);
    repeat (BDIV / 2) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("%s_bit%0d", tag, i), 32'(line_of(odd)), 32'(f[i]));
      if (i < 10) begin
        if (i == inject_bit) begin
          tx_data  = 8'hFF;
          tx_start = 1'b1;
          @(negedge clk);
          tx_start = 1'b0;
          repeat (BDIV - 1) @(negedge clk);
        end else begin
          repeat (BDIV) @(negedge clk);
        end
      end
    end
    n = 0;
    while (done_of(odd) !== 1'b1 && n < 2 * BDIV) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_tx_done_seen"}, 32'(done_of(odd)), 32'd1);
  endtask

  initial begin
    int t0, t1, n, d0, r0, lows;
    logic [7:0] b;

    #20;
    @(negedge clk);
    check("rst_tx_out", 32'(tx_out), 32'd1);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_baud_tick", 32'(baud_tick), 32'd0);
    check("rst_rx_done", 32'(rx_done), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0;

    n = 0;
    while (baud_tick !== 1'b1 && n < 3 * BDIV) begin @(negedge clk); n++; end
    t0 = cyc;
    @(negedge clk);
    n = 0;
    while (baud_tick !== 1'b1 && n < 3 * BDIV) begin @(negedge clk); n++; end
    t1 = cyc;
    check("baud_period", 32'(t1 - t0), 32'(BDIV));

    // Single frame 0xA5, even parity
    d0 = tx_done_cnt; r0 = rx_done_cnt;
    drive_start(1'b0, 8'hA5);
    check_frame(1'b0, 8'hA5, "a5", -1);
    repeat (BDIV) @(negedge clk);
    check("a5_tx_done_count", 32'(tx_done_cnt - d0), 32'd1);
    check("a5_rx_done_count", 32'(rx_done_cnt - r0), 32'd1);
    check("a5_rx_data_hold", 32'(rx_data), 32'hA5);

    // Back-to-back random bytes
    d0 = tx_done_cnt; r0 = rx_done_cnt;
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom_range(0, 255));
      drive_start(1'b0, b);
      check_frame(1'b0, b, $sformatf("b2b%0d", k), -1);
    end
    repeat (BDIV) @(negedge clk);
    check("b2b_tx_done_count", 32'(tx_done_cnt - d0), 32'd3);
    check("b2b_rx_done_count", 32'(rx_done_cnt - r0), 32'd3);
    check("b2b_q_empty", 32'(q.size()), 32'd0);

    // Odd-parity instance, 0x01
    r0 = rx_done_cnt_o;
    drive_start(1'b1, 8'h01);
    check_frame(1'b1, 8'h01, "odd01", -1);
    repeat (BDIV) @(negedge clk);
    check("odd01_rx_done_count", 32'(rx_done_cnt_o - r0), 32'd1);
    check("odd01_rx_data", 32'(rx_data_o), 32'h01);

    // Reset in the middle of DATA
    d0 = tx_done_cnt; r0 = rx_done_cnt;
    drive_start(1'b0, 8'h5A);
    wait_low(1'b0, "rstmid");
    repeat (3 * BDIV) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_tx_out", 32'(tx_out), 32'd1);
    q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12 * BDIV) @(negedge clk);
    check("rstmid_no_tx_done", 32'(tx_done_cnt - d0), 32'd0);
    check("rstmid_no_rx_done", 32'(rx_done_cnt - r0), 32'd0);
    check("rstmid_rx_data_cleared", 32'(rx_data), 32'd0);
    drive_start(1'b0, 8'hC3);
    check_frame(1'b0, 8'hC3, "after_rst", -1);
    repeat (BDIV) @(negedge clk);
    check("after_rst_rx_data", 32'(rx_data), 32'hC3);

    // Spurious tx_start during DATA of 0x3C must be ignored
    d0 = tx_done_cnt; r0 = rx_done_cnt;
    drive_start(1'b0, 8'h3C);
    check_frame(1'b0, 8'h3C, "ign3c", 3);
    lows = 0;
    repeat (3 * 11 * BDIV) begin
      @(negedge clk);
      if (tx_out !== 1'b1) lows++;
    end
    check("ign3c_line_idle_after", 32'(lows), 32'd0);
    check("ign3c_tx_done_count", 32'(tx_done_cnt - d0), 32'd1);
    check("ign3c_rx_done_count", 32'(rx_done_cnt - r0), 32'd1);
    check("ign3c_rx_data", 32'(rx_data), 32'h3C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
